// File: rtl/fmaj_pkg.sv
// Shared helpers and state encoding for the folded majority evaluator.
// Pure constant functions; no logic.
package fmaj_pkg;

    localparam logic S_ACCUM = 1'b0;
    localparam logic S_HOLD  = 1'b1;

    function automatic int f_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int f_nbeats(input int n, input int w);
        return (n + w - 1) / w;
    endfunction

    // Number of live vote bits in the final beat.
    function automatic int f_lastw(input int n, input int w);
        return n - (f_nbeats(n, w) - 1) * w;
    endfunction

    function automatic int f_maj_thr(input int n);
        return n / 2 + 1;
    endfunction

endpackage

// File: rtl/fmaj_popcnt_w.sv
// Combinational W-bit popcount built as a recursive halving adder tree.
// Latency: 0 cycles. Backpressure: none (pure combinational).
module fmaj_popcnt_w
    import fmaj_pkg::*;
#(
    parameter  int W  = 8,
    localparam int OW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits_i,
    output logic [OW-1:0] cnt_o
);

    generate
        if (W == 1) begin : g_leaf
            assign cnt_o = bits_i;
        end else begin : g_split
            localparam int WL = W / 2;
            localparam int WH = W - WL;
            localparam int OL = f_clog2(WL + 1);
            localparam int OH = f_clog2(WH + 1);

            logic [OL-1:0] cnt_lo;
            logic [OH-1:0] cnt_hi;

            fmaj_popcnt_w #(.W(WL)) u_lo (
                .bits_i (bits_i[WL-1:0]),
                .cnt_o  (cnt_lo)
            );

            fmaj_popcnt_w #(.W(WH)) u_hi (
                .bits_i (bits_i[W-1:WL]),
                .cnt_o  (cnt_hi)
            );

            assign cnt_o = OW'(cnt_lo) + OW'(cnt_hi);
        end
    endgenerate

endmodule

// File: rtl/folded_maj_eval.sv
// Folded majority/threshold evaluator: N votes arrive as NB beats of W bits; optional out_count via FMAJ_COUNT_OUT_EN.
// Latency: out_valid rises the cycle after the final beat is accepted; one result per NB cycles sustained.
// Backpressure: in_ready = !out_valid || out_ready; a held result stalls the input stream.
module folded_maj_eval
    import fmaj_pkg::*;
#(
    parameter int N  = 55,
    parameter int W  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [CW-1:0] thr_i,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef FMAJ_COUNT_OUT_EN
    output logic [CW-1:0] out_count,
`endif
    output logic          out_y
);

    localparam int NB    = f_nbeats(N, W);
    localparam int LASTW = f_lastw(N, W);
    localparam int BCW   = (NB > 1) ? f_clog2(NB) : 1;
    localparam int PW    = f_clog2(W + 1);
    localparam logic [W-1:0]   LAST_MASK = {W{1'b1}} >> (W - LASTW);
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(NB - 1);

    logic           state_q, state_d;
    logic [BCW-1:0] beat_q, beat_d;
    logic [CW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  thr_q, thr_d;
    logic           out_y_q, out_y_d;

    logic           accept;
    logic           is_first;
    logic           is_last;
    logic [W-1:0]   beat_bits;
    logic [PW-1:0]  beat_cnt;
    logic [CW-1:0]  acc_sum;
    logic [CW-1:0]  thr_smp;
    logic [CW-1:0]  thr_eff;

    assign out_valid = (state_q == S_HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign is_first  = (beat_q == '0);
    assign is_last   = (beat_q == BEAT_LAST);

    // Pad bits beyond vote N-1 in the final beat must never be counted.
    assign beat_bits = is_last ? (in_data & LAST_MASK) : in_data;

    fmaj_popcnt_w #(.W(W)) u_popcnt (
        .bits_i (beat_bits),
        .cnt_o  (beat_cnt)
    );

    assign acc_sum = (is_first ? '0 : acc_q) + CW'(beat_cnt);
    assign thr_smp = (thr_i == '0) ? CW'(f_maj_thr(N)) : thr_i;
    // With a single beat the threshold is sampled and used in the same cycle.
    assign thr_eff = is_first ? thr_smp : thr_q;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        acc_d   = acc_q;
        thr_d   = thr_q;
        out_y_d = out_y_q;

        if (state_q == S_HOLD && out_ready) begin
            state_d = S_ACCUM;
        end

        if (accept) begin
            acc_d = acc_sum;
            if (is_first) begin
                thr_d = thr_smp;
            end
            if (is_last) begin
                out_y_d = (acc_sum >= thr_eff);
                state_d = S_HOLD;
                beat_d  = '0;
            end else begin
                beat_d  = beat_q + BCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ACCUM;
            beat_q  <= '0;
            acc_q   <= '0;
            thr_q   <= '0;
            out_y_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            acc_q   <= acc_d;
            thr_q   <= thr_d;
            out_y_q <= out_y_d;
        end
    end

    assign out_y = out_y_q;

`ifdef FMAJ_COUNT_OUT_EN
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (accept && is_last) begin
            count_d = acc_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out_count = count_q;
`endif

endmodule

// File: tb/tb_folded_maj_eval.sv
// Directed-vector bench for folded_maj_eval (N=55, W=8); out_count checks only when FMAJ_COUNT_OUT_EN is defined.
module tb_folded_maj_eval;

    localparam int N  = 55;
    localparam int W  = 8;
    localparam int CW = 6;

    localparam logic [63:0] V_ALL   = 64'h007F_FFFF_FFFF_FFFF; // 55 ones
    localparam logic [63:0] V_28    = 64'h000F_0F0F_0F0F_0F0F; // 28 ones
    localparam logic [63:0] V_27    = 64'h000F_0F0F_0F0F_0F0E; // 27 ones
    localparam logic [63:0] V_PAD   = 64'h0080_0000_0000_0000; // only the pad bit
    localparam logic [63:0] V_7     = 64'h007F_0000_0000_0000; // 7 ones in last beat
    localparam logic [63:0] V_54    = 64'h007F_FFFF_FFFF_FFFE; // 54 ones
    localparam logic [63:0] V_1     = 64'h0000_0000_0001_0000; // 1 one

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data   = '0;
    logic [CW-1:0] thr_i     = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_y;
`ifdef FMAJ_COUNT_OUT_EN
    logic [CW-1:0] out_count;
`endif

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    folded_maj_eval #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .thr_i     (thr_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FMAJ_COUNT_OUT_EN
        .out_count (out_count),
`endif
        .out_y     (out_y)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drives beats first..last of vector v; the call starts and ends at posedge+1.
    task automatic send_vec(input logic [63:0] v, input logic [CW-1:0] thr0,
                            input logic [CW-1:0] thrl, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            int n;
            n        = 0;
            in_valid = 1'b1;
            in_data  = v[k*W +: W];
            thr_i    = (k == 0) ? thr0 : thrl;
            while (!in_ready && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 20) check("in_ready_timeout", 0, 1);
            if (k == 6) check("vld_before_last", int'(out_valid), 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = 8'hA5;
        thr_i    = 6'd3;
        if (last == 6) check("vld_after_last", int'(out_valid), 1);
    endtask

    task automatic check_res(input string tag, input int y, input int cnt);
        check({tag, "_y"}, int'(out_y), y);
`ifdef FMAJ_COUNT_OUT_EN
        check({tag, "_cnt"}, int'(out_count), cnt);
`else
        if (cnt < 0) check({tag, "_cnt_arg"}, cnt, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check_res("rst", 0, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Full vector, default majority threshold 28
        send_vec(V_ALL, 6'd0, 6'd0, 0, 6);
        check_res("t1_all", 1, 55);

        send_vec(V_28, 6'd0, 6'd0, 0, 6);
        check_res("t2_28", 1, 28);
        send_vec(V_27, 6'd0, 6'd0, 0, 6);
        check_res("t2_27", 0, 27);

        send_vec(V_PAD, 6'd0, 6'd0, 0, 6);
        check_res("t3_pad", 0, 0);
        send_vec(V_7, 6'd0, 6'd0, 0, 6);
        check_res("t3_7f", 0, 7);

        // Backpressure: result held, input stalled, then consume + beat 0 together
        send_vec(V_ALL, 6'd0, 6'd0, 0, 6);
        check_res("t4_a", 1, 55);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h0E;
        thr_i     = 6'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t4_stall_in_ready", int'(in_ready), 0);
            check("t4_stall_vld", int'(out_valid), 1);
            check("t4_stall_y", int'(out_y), 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_consumed", int'(out_valid), 0);
        send_vec(V_27, 6'd0, 6'd0, 1, 6);
        check_res("t4_b", 0, 27);

        // Threshold latched on beat 0 only
        send_vec(V_54, 6'd55, 6'd1, 0, 6);
        check_res("t5_54", 0, 54);
        send_vec(V_ALL, 6'd55, 6'd1, 0, 6);
        check_res("t5_55", 1, 55);
        send_vec(V_ALL, 6'd60, 6'd0, 0, 6);
        check_res("t5_over", 0, 55);
        send_vec(V_1, 6'd1, 6'd0, 0, 6);
        check_res("t5_or", 1, 1);

        // Reset while a result is held
        send_vec(V_ALL, 6'd0, 6'd0, 0, 6);
        check_res("t6_pre", 1, 55);
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t6_hold_rst_vld", int'(out_valid), 0);
        check("t6_hold_rst_rdy", int'(in_ready), 1);
        check_res("t6_hold_rst", 0, 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Reset mid-vector discards the partial sum and beat position
        send_vec(V_ALL, 6'd0, 6'd0, 0, 2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_mid_rst_vld", int'(out_valid), 0);
        check("t6_mid_rst_rdy", int'(in_ready), 1);
        check_res("t6_mid_rst", 0, 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send_vec(V_28, 6'd0, 6'd0, 0, 6);
        check_res("t6_after", 1, 28);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/folded_maj_eval.md
Name: folded_maj_eval

Overview:
Parametrised, folded (serial) majority/threshold evaluator, the sequential successor to the flat 55-input majority gate. It accepts an N-bit vote vector as ceil(N/W) beats of W bits over a valid/ready stream. It accumulates the popcount and compares it against a programmable bias threshold. It sits ahead of the decision logic in the folded bias-decomposition datapath and trades area for throughput, at one result per NB beats.

Parameters:
N, 55, total votes per vector (N >= 2)
W, 8, bits per input beat (1 <= W <= N)
CW, $clog2(N+1), popcount/threshold width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
in_data  in  W  vote bits; beat k carries votes x[k*W +: W]
thr_i  in  CW  threshold, sampled on beat 0; 0 selects default majority floor(N/2)+1
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
out_y  out  1  1 iff popcount >= effective threshold

Behaviour:
- NB = ceil(N/W). LASTW = N - (NB-1)*W. On beat NB-1, in_data bits [W-1:LASTW] are masked to 0 before counting.
- Reset values: in_ready=1, out_valid=0, out_y=0, beat counter=0, accumulator=0, stored threshold=0.
- States:
  - ACCUM: beat counter b in 0..NB-1.
  - HOLD: result pending.
- ACCUM, beat accepted:
  - acc <= (b==0 ? 0 : acc) + popcnt(masked in_data).
  - b==0: thr_q <= (thr_i==0) ? floor(N/2)+1 : thr_i.
  - b==NB-1: out_y <= (acc_next >= thr_q_eff), where thr_q_eff is the value being sampled if NB==1.
  - b==NB-1: out_valid <= 1; b <= 0; go to HOLD. Otherwise b <= b+1.
- No beat in ACCUM: all state holds. Gaps between beats are legal.
- Latency: out_valid rises in the cycle after the final beat is accepted.
- in_ready = !out_valid || out_ready. In HOLD with out_ready=1, the result is consumed and beat 0 of the next vector may be accepted in the same cycle. Sustained throughput: 1 result per NB cycles, zero bubbles.
- HOLD with out_ready=0: out_y and out_valid are stable, in_ready=0, input is stalled.
- Accumulator width is CW. The maximum sum is N, so it never overflows.
- A threshold greater than N forces out_y=0. A threshold of 1 gives OR semantics.
- in_data and thr_i are ignored when not accepted.
- rst_n asserted mid-vector or mid-HOLD: immediate return to reset values. Partial sums are discarded. The next accepted beat is treated as beat 0.
- No X propagation: the accumulator only updates on accepted beats.

Optional Feature:
FMAJ_COUNT_OUT_EN
- Defined: adds output port out_count [CW-1:0], the final popcount. It is registered alongside out_y, valid with out_valid, stable under backpressure, and resets to 0.
- Undefined: the port is absent. Only out_y is produced, and synthesis drops the final-count register.

Decomposition:
- Shared package fmaj_pkg holds:
  - function f_clog2;
  - function f_nbeats(N,W);
  - function f_lastw(N,W);
  - function f_maj_thr(N) = N/2+1;
  - state encoding constants S_ACCUM=1'b0, S_HOLD=1'b1.
- One sub-module: fmaj_popcnt_w (parameter W). It is a combinational W-bit popcount with a $clog2(W+1)-bit output, built as an adder tree. The top instantiates it once.

Test Plan:
1. N=55, W=8, thr_i=0; 7 beats of 8'hFF, out_ready=1 -> out_valid one cycle after beat 7; out_y=1; out_count=55.
2. Exactly 28 ones spread over 7 beats -> out_y=1. Same vector with one 1 cleared (27 ones) -> out_y=0.
3. Beats 0..5 = 8'h00, beat 6 = 8'h80 (only the masked bit 7 set) -> out_count=0, out_y=0. Beat 6 = 8'h7F -> out_count=7, out_y=0.
4. Two vectors back-to-back, out_ready=0 for 5 cycles after the first result -> in_ready=0 throughout and out_y stable. Raise out_ready -> first result consumed and beat 0 of the second accepted in the same cycle; second result correct.
5. thr_i=55 on beat 0, then thr_i changed to 1 on later beats, vector with 54 ones -> out_y=0 (threshold latched on beat 0 only). All 55 ones -> out_y=1.
6. Accept 3 beats of 8'hFF, pulse rst_n low asynchronously mid-cycle -> outputs go to reset values immediately. A following full vector of 28 ones gives out_count=28, out_y=1, with no residue from before reset.
